unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one 128-bit-line main memory between the instruction-cache miss port and the data-cache miss port, replacing the two separate memories in the system top level.
- Arbitrates round-robin and sequences each transfer through the memory busywait handshake.
- Returns each response to its requester through that requester's own busywait/data interface.
- Sits between the CPU's cache ports and a single unified memory module.

Parameters:
- ADDR_W, 6, block address width per requester.
- TIMEOUT, 255, max cycles a grant may wait on MEM_BUSYWAIT before abort (8-bit counter).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- INST_MEM_READ  in  1  I-cache block read request.
- INST_MEM_ADDRESS  in  6  I-cache block address.
- INST_MEM_DATA  out  128  I-cache read block.
- INST_MEM_BUSYWAIT  out  1  I-cache stall.
- READ_DATA_MEM2CAC  in  1  D-cache read request.
- WRITE_DATA_MEM2CAC  in  1  D-cache write request.
- MEM_ADDRESS_MEM2CAC  in  6  D-cache block address.
- OUTDATA_MEM2CAC  in  32  D-cache write block.
- INDATA_MEM2CAC  out  32  D-cache read block.
- BUSYWAIT_MEM2CAC  out  1  D-cache stall.
- MEM_READ  out  1  unified memory read.
- MEM_WRITE  out  1  unified memory write.
- MEM_ADDRESS  out  7  {region, block}; region 0 = instruction, 1 = data.
- MEM_WRITEDATA  out  128  {96'b0, OUTDATA_MEM2CAC} for data writes; 0 otherwise.
- MEM_READDATA  in  128  line from memory.
- MEM_BUSYWAIT  in  1  memory busy.
- ARB_ERROR  out  1  sticky timeout flag.

Behaviour:
- States: IDLE, GRANT_I, GRANT_D, RELEASE. Registers: last_served (I/D), served (I/D), wait_cnt[7:0], response regs inst_line[127:0], data_word[31:0].
- Reset (RESET low, any time, including mid-transfer):
  - state IDLE; last_served = I, so D wins the first tie.
  - MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA = 0; INST_MEM_DATA = 0; INDATA_MEM2CAC = 0; ARB_ERROR = 0.
  - Memory is assumed reset by the same signal.
- Requester active: I = INST_MEM_READ; D = READ_DATA_MEM2CAC | WRITE_DATA_MEM2CAC.
- D-side with both read and write high is treated as a write.
- IDLE:
  - Only one active → grant it.
  - Both active → grant the one not equal to last_served.
  - Transition at the clock edge; wait_cnt cleared.
- GRANT_x:
  - MEM_READ/MEM_WRITE, MEM_ADDRESS and MEM_WRITEDATA are registered outputs driven for the whole state. First driven in the cycle after grant.
  - Address and data are captured at grant and held stable even if the requester changes inputs.
  - wait_cnt increments each cycle.
  - Completion = posedge with wait_cnt ≥ 1 and MEM_BUSYWAIT = 0. The first issue cycle ignores busywait, which covers the memory's one-cycle busy assertion latency.
  - On completion: latch MEM_READDATA into inst_line (I) or MEM_READDATA[31:0] into data_word (D read); writes leave regs unchanged. Then served = x, last_served = x, go to RELEASE.
  - wait_cnt = TIMEOUT without completion: set ARB_ERROR, latch zero data, go to RELEASE.
- RELEASE (exactly 1 cycle):
  - MEM_READ/MEM_WRITE = 0, so memory sees the request drop.
  - Then IDLE. A pending other requester is granted from IDLE the next cycle, giving a minimum 1 idle memory cycle between transfers.
- Busywait:
  - INST_MEM_BUSYWAIT = INST_MEM_READ & !(state == RELEASE & served == I). Same form for BUSYWAIT_MEM2CAC with D.
  - Combinational from request and registered state, so a requester raising its request sees busywait in the same cycle.
- INST_MEM_DATA / INDATA_MEM2CAC are driven continuously from the response regs and hold until the next completion.
- Requester drops its request mid-grant: the transfer still completes (memory is not aborted), the result is latched, and RELEASE proceeds normally.
- Minimum latency, request to busywait low: 1 (arb) + memory busy cycles + 1 (release view).
- Throughput: one transfer per (memory latency + 3) cycles under contention; strict alternation when both are continuously active, so neither requester starves.

Test Plan:
- Reset low mid-GRANT_D with MEM_WRITE high → MEM_WRITE = 0 immediately (async), state IDLE, ARB_ERROR = 0, outputs 0.
- I-read addr 0x05 alone, memory returns 128'hA5…A5 after 5 busy cycles → MEM_ADDRESS = 7'h05, INST_MEM_DATA = A5…A5, INST_MEM_BUSYWAIT falls 1 cycle after MEM_BUSYWAIT falls.
- D-write addr 0x12 data 32'hDEADBEEF → MEM_ADDRESS = 7'h52, MEM_WRITEDATA = {96'b0, DEADBEEF}, MEM_READ = 0 throughout.
- I-read and D-read asserted in the same cycle after reset → D granted first, I second. Held continuously: grants alternate D, I, D, I with one RELEASE cycle between each.
- D-read granted, MEM_BUSYWAIT stuck high → after 255 cycles ARB_ERROR = 1 (sticky), INDATA_MEM2CAC = 0, BUSYWAIT_MEM2CAC low for one cycle, the next I-request is still serviced.
- I-cache drops INST_MEM_READ 2 cycles into its grant → MEM_READ held until completion, INST_MEM_BUSYWAIT = 0, a queued D-request is granted after RELEASE.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter that shares one 128-bit-line memory between the I-cache and D-cache miss ports.
// Each transfer runs IDLE -> GRANT_x -> RELEASE, and the result is handed back through that requester's own busywait.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              INST_MEM_READ,
    input  logic [ADDR_W-1:0] INST_MEM_ADDRESS,
    output logic [127:0]      INST_MEM_DATA,
    output logic              INST_MEM_BUSYWAIT,
    input  logic              READ_DATA_MEM2CAC,
    input  logic              WRITE_DATA_MEM2CAC,
    input  logic [ADDR_W-1:0] MEM_ADDRESS_MEM2CAC,
    input  logic [31:0]       OUTDATA_MEM2CAC,
    output logic [31:0]       INDATA_MEM2CAC,
    output logic              BUSYWAIT_MEM2CAC,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W:0]   MEM_ADDRESS,
    output logic [127:0]      MEM_WRITEDATA,
    input  logic [127:0]      MEM_READDATA,
    input  logic              MEM_BUSYWAIT,
    output logic              ARB_ERROR
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t            state_reg, state_next;
    logic              last_d_reg, last_d_next;
    logic              served_d_reg, served_d_next;
    logic [7:0]        wait_cnt_reg, wait_cnt_next;
    logic [127:0]      inst_line_reg, inst_line_next;
    logic [31:0]       data_word_reg, data_word_next;
    logic              mem_read_reg, mem_read_next;
    logic              mem_write_reg, mem_write_next;
    logic [ADDR_W:0]   mem_addr_reg, mem_addr_next;
    logic [127:0]      mem_wdata_reg, mem_wdata_next;
    logic              error_reg, error_next;
    logic              i_act, d_act, finish;

    assign i_act = INST_MEM_READ;
    assign d_act = READ_DATA_MEM2CAC | WRITE_DATA_MEM2CAC;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg     <= IDLE;
            last_d_reg    <= 1'b0;
            served_d_reg  <= 1'b0;
            wait_cnt_reg  <= '0;
            inst_line_reg <= '0;
            data_word_reg <= '0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            last_d_reg    <= last_d_next;
            served_d_reg  <= served_d_next;
            wait_cnt_reg  <= wait_cnt_next;
            inst_line_reg <= inst_line_next;
            data_word_reg <= data_word_next;
            mem_read_reg  <= mem_read_next;
            mem_write_reg <= mem_write_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            error_reg     <= error_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        last_d_next    = last_d_reg;
        served_d_next  = served_d_reg;
        wait_cnt_next  = wait_cnt_reg;
        inst_line_next = inst_line_reg;
        data_word_next = data_word_reg;
        mem_read_next  = mem_read_reg;
        mem_write_next = mem_write_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        error_next     = error_reg;
        finish         = 1'b0;

        case (state_reg)
            IDLE: begin
                wait_cnt_next = '0;
                // On a tie D wins unless it was the last one served.
                if (d_act && (!i_act || !last_d_reg)) begin
                    state_next     = GRANT_D;
                    mem_read_next  = !WRITE_DATA_MEM2CAC;
                    mem_write_next = WRITE_DATA_MEM2CAC;
                    mem_addr_next  = {1'b1, MEM_ADDRESS_MEM2CAC};
                    mem_wdata_next = WRITE_DATA_MEM2CAC ? {96'b0, OUTDATA_MEM2CAC} : '0;
                end else if (i_act) begin
                    state_next     = GRANT_I;
                    mem_read_next  = 1'b1;
                    mem_write_next = 1'b0;
                    mem_addr_next  = {1'b0, INST_MEM_ADDRESS};
                    mem_wdata_next = '0;
                end
            end
            GRANT_I, GRANT_D: begin
                // The first issue cycle predates the memory's busy response, so it never completes.
                if (wait_cnt_reg != 8'd0 && !MEM_BUSYWAIT) begin
                    finish = 1'b1;
                    if (state_reg == GRANT_I)
                        inst_line_next = MEM_READDATA;
                    else if (mem_read_reg)
                        data_word_next = MEM_READDATA[31:0];
                end else if (wait_cnt_reg == TIMEOUT_CNT) begin
                    finish     = 1'b1;
                    error_next = 1'b1;
                    if (state_reg == GRANT_I)
                        inst_line_next = '0;
                    else if (mem_read_reg)
                        data_word_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
                if (finish) begin
                    state_next     = RELEASE;
                    served_d_next  = (state_reg == GRANT_D);
                    last_d_next    = (state_reg == GRANT_D);
                    mem_read_next  = 1'b0;
                    mem_write_next = 1'b0;
                    mem_addr_next  = '0;
                    mem_wdata_next = '0;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign INST_MEM_BUSYWAIT = INST_MEM_READ & !(state_reg == RELEASE && !served_d_reg);
    assign BUSYWAIT_MEM2CAC  = d_act & !(state_reg == RELEASE && served_d_reg);
    assign INST_MEM_DATA     = inst_line_reg;
    assign INDATA_MEM2CAC    = data_word_reg;
    assign MEM_READ          = mem_read_reg;
    assign MEM_WRITE         = mem_write_reg;
    assign MEM_ADDRESS       = mem_addr_reg;
    assign MEM_WRITEDATA     = mem_wdata_reg;
    assign ARB_ERROR         = error_reg;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter: behavioural memory, transaction monitor and a round-level
// reference model that predicts grant order, completion cycle, returned data and the error flag.
module tb_unified_mem_arbiter;

    localparam int TIMEOUT = 255;

    logic         CLK;
    logic         RESET;
    logic         INST_MEM_READ;
    logic [5:0]   INST_MEM_ADDRESS;
    logic [127:0] INST_MEM_DATA;
    logic         INST_MEM_BUSYWAIT;
    logic         READ_DATA_MEM2CAC;
    logic         WRITE_DATA_MEM2CAC;
    logic [5:0]   MEM_ADDRESS_MEM2CAC;
    logic [31:0]  OUTDATA_MEM2CAC;
    logic [31:0]  INDATA_MEM2CAC;
    logic         BUSYWAIT_MEM2CAC;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [6:0]   MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
    logic         ARB_ERROR;

    unified_mem_arbiter #(.ADDR_W(6), .TIMEOUT(TIMEOUT)) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .INST_MEM_READ       (INST_MEM_READ),
        .INST_MEM_ADDRESS    (INST_MEM_ADDRESS),
        .INST_MEM_DATA       (INST_MEM_DATA),
        .INST_MEM_BUSYWAIT   (INST_MEM_BUSYWAIT),
        .READ_DATA_MEM2CAC   (READ_DATA_MEM2CAC),
        .WRITE_DATA_MEM2CAC  (WRITE_DATA_MEM2CAC),
        .MEM_ADDRESS_MEM2CAC (MEM_ADDRESS_MEM2CAC),
        .OUTDATA_MEM2CAC     (OUTDATA_MEM2CAC),
        .INDATA_MEM2CAC      (INDATA_MEM2CAC),
        .BUSYWAIT_MEM2CAC    (BUSYWAIT_MEM2CAC),
        .MEM_READ            (MEM_READ),
        .MEM_WRITE           (MEM_WRITE),
        .MEM_ADDRESS         (MEM_ADDRESS),
        .MEM_WRITEDATA       (MEM_WRITEDATA),
        .MEM_READDATA        (MEM_READDATA),
        .MEM_BUSYWAIT        (MEM_BUSYWAIT),
        .ARB_ERROR           (ARB_ERROR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic [6:0]   addr;
        logic         rd;
        logic         wr;
        logic [127:0] wd;
    } txn_t;

    int tests = 0;
    int fails = 0;

    logic [127:0] tb_mem  [128];
    logic [127:0] ref_mem [128];
    logic [127:0] m_inst;
    logic [31:0]  m_data;
    bit           m_last_d;
    bit           m_err;

    int   lat_i, lat_d;
    bit   stuck_d;
    txn_t txq[$];
    txn_t cur;
    bit   mon_active;
    int   mcnt;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory: busy for lat cycles from the first request cycle, then presents its line; writes land once not busy.
    initial begin
        mon_active   = 1'b0;
        mcnt         = 0;
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = '0;
        forever begin
            @(negedge CLK);
            if (!RESET || !(MEM_READ || MEM_WRITE)) begin
                mon_active   = 1'b0;
                MEM_BUSYWAIT = 1'b0;
            end else begin
                if (!mon_active) begin
                    mon_active = 1'b1;
                    cur.addr   = MEM_ADDRESS;
                    cur.rd     = MEM_READ;
                    cur.wr     = MEM_WRITE;
                    cur.wd     = MEM_WRITEDATA;
                    txq.push_back(cur);
                    mcnt = MEM_ADDRESS[6] ? lat_d : lat_i;
                end else begin
                    check("hold_addr", 160'(MEM_ADDRESS), 160'(cur.addr));
                    check("hold_rw", 160'({MEM_READ, MEM_WRITE}), 160'({cur.rd, cur.wr}));
                    check("hold_wdata", 160'(MEM_WRITEDATA), 160'(cur.wd));
                    if (mcnt > 0) mcnt--;
                end
                MEM_BUSYWAIT = (mcnt > 0) || (stuck_d && MEM_ADDRESS[6]);
                if (MEM_BUSYWAIT) begin
                    MEM_READDATA = {4{$urandom}};
                end else begin
                    if (MEM_WRITE) tb_mem[MEM_ADDRESS] = MEM_WRITEDATA;
                    MEM_READDATA = tb_mem[MEM_ADDRESS];
                end
            end
        end
    end

    // One round: requesters raise together from IDLE, each drops its request when its busywait falls.
    task automatic run_round(input bit do_i, input bit do_d, input bit d_wr,
                             input logic [5:0] ai, input logic [5:0] ad, input logic [31:0] wd,
                             input int li, input int ld, input bit stk, input int i_drop);
        bit           d_first, i_pend, d_pend;
        int           ei, ed, exp_i, exp_d, last_cyc;
        logic [127:0] exp_line;
        logic [31:0]  exp_word;
        txn_t         t_i, t_d, t_obs;

        ei = (li < 1) ? 1 : li;
        ed = stk ? TIMEOUT : ((ld < 1) ? 1 : ld);
        d_first = do_d && (!do_i || !m_last_d);
        // Served requester sees busywait low max(1,lat)+2 cycles after raising; the other waits a further idle cycle.
        if (do_i && do_d) begin
            if (d_first) begin
                exp_d = ed + 2;
                exp_i = exp_d + ei + 3;
            end else begin
                exp_i = ei + 2;
                exp_d = exp_i + ed + 3;
            end
        end else begin
            exp_i = ei + 2;
            exp_d = ed + 2;
        end
        last_cyc = ((do_i && exp_i > exp_d) || !do_d) ? exp_i + 1 : exp_d + 1;

        exp_line = ref_mem[{1'b0, ai}];
        exp_word = stk ? 32'h0 : ref_mem[{1'b1, ad}][31:0];
        t_i.addr = {1'b0, ai};
        t_i.rd   = 1'b1;
        t_i.wr   = 1'b0;
        t_i.wd   = '0;
        t_d.addr = {1'b1, ad};
        t_d.rd   = !d_wr;
        t_d.wr   = d_wr;
        t_d.wd   = d_wr ? {96'b0, wd} : 128'b0;

        lat_i   = li;
        lat_d   = ld;
        stuck_d = stk;

        @(negedge CLK);
        INST_MEM_READ       = do_i;
        INST_MEM_ADDRESS    = ai;
        WRITE_DATA_MEM2CAC  = do_d && d_wr;
        READ_DATA_MEM2CAC   = do_d && (!d_wr || ($urandom_range(0, 1) == 1));
        MEM_ADDRESS_MEM2CAC = ad;
        OUTDATA_MEM2CAC     = wd;
        i_pend = do_i;
        d_pend = do_d;

        for (int cyc = 1; cyc <= last_cyc; cyc++) begin
            @(negedge CLK);
            if (cyc == 2) begin
                if (d_first) begin
                    MEM_ADDRESS_MEM2CAC = 6'($urandom);
                    OUTDATA_MEM2CAC     = $urandom;
                end else if (do_i) begin
                    INST_MEM_ADDRESS = 6'($urandom);
                end
            end
            if (i_pend && i_drop != 0 && cyc == i_drop) begin
                INST_MEM_READ = 1'b0;
                i_pend = 1'b0;
                #1;
                check("i_drop_busywait", 160'(INST_MEM_BUSYWAIT), 160'(0));
            end else if (i_pend && !INST_MEM_BUSYWAIT) begin
                check("i_done_cycle", 160'(cyc), 160'(exp_i));
                check("i_line", 160'(INST_MEM_DATA), 160'(exp_line));
                $display("[TB] I read  addr %02h line %h at cycle %0d", ai, INST_MEM_DATA, cyc);
                INST_MEM_READ = 1'b0;
                i_pend = 1'b0;
            end
            if (d_pend && !BUSYWAIT_MEM2CAC) begin
                check("d_done_cycle", 160'(cyc), 160'(exp_d));
                if (d_wr)
                    check("d_word_kept", 160'(INDATA_MEM2CAC), 160'(m_data));
                else
                    check("d_word", 160'(INDATA_MEM2CAC), 160'(exp_word));
                $display("[TB] D %s addr %02h word %h at cycle %0d", d_wr ? "write" : "read ", ad,
                         d_wr ? wd : INDATA_MEM2CAC, cyc);
                READ_DATA_MEM2CAC  = 1'b0;
                WRITE_DATA_MEM2CAC = 1'b0;
                d_pend = 1'b0;
            end
        end
        check("i_pending", 160'(i_pend), 160'(0));
        check("d_pending", 160'(d_pend), 160'(0));
        INST_MEM_READ      = 1'b0;
        READ_DATA_MEM2CAC  = 1'b0;
        WRITE_DATA_MEM2CAC = 1'b0;
        stuck_d = 1'b0;

        if (do_i) m_inst = exp_line;
        if (do_d) begin
            if (d_wr) ref_mem[{1'b1, ad}] = {96'b0, wd};
            else      m_data = exp_word;
            if (stk) m_err = 1'b1;
        end
        m_last_d = (do_i && do_d) ? !d_first : do_d;

        check("inst_data", 160'(INST_MEM_DATA), 160'(m_inst));
        check("d_data", 160'(INDATA_MEM2CAC), 160'(m_data));
        check("arb_error", 160'(ARB_ERROR), 160'(m_err));
        check("txn_count", 160'(txq.size()), 160'(int'(do_i) + int'(do_d)));
        if (d_first) begin
            if (txq.size() > 0) begin t_obs = txq.pop_front(); check("txn_d", 160'(t_obs), 160'(t_d)); end
            if (do_i && txq.size() > 0) begin t_obs = txq.pop_front(); check("txn_i", 160'(t_obs), 160'(t_i)); end
        end else begin
            if (do_i && txq.size() > 0) begin t_obs = txq.pop_front(); check("txn_i", 160'(t_obs), 160'(t_i)); end
            if (do_d && txq.size() > 0) begin t_obs = txq.pop_front(); check("txn_d", 160'(t_obs), 160'(t_d)); end
        end
        txq.delete();
    endtask

    initial begin
        logic [1:0] sel;

        RESET               = 1'b0;
        INST_MEM_READ       = 1'b0;
        INST_MEM_ADDRESS    = '0;
        READ_DATA_MEM2CAC   = 1'b0;
        WRITE_DATA_MEM2CAC  = 1'b0;
        MEM_ADDRESS_MEM2CAC = '0;
        OUTDATA_MEM2CAC     = '0;
        lat_i = 0;
        lat_d = 0;
        stuck_d = 1'b0;
        for (int i = 0; i < 128; i++) begin
            tb_mem[i]  = {$urandom, $urandom, $urandom, $urandom};
            ref_mem[i] = tb_mem[i];
        end
        tb_mem[5]  = {16{8'hA5}};
        ref_mem[5] = {16{8'hA5}};
        m_inst   = '0;
        m_data   = '0;
        m_last_d = 1'b0;
        m_err    = 1'b0;

        repeat (3) @(negedge CLK);
        check("rst_mem_read", 160'(MEM_READ), 160'(0));
        check("rst_mem_write", 160'(MEM_WRITE), 160'(0));
        check("rst_mem_addr", 160'(MEM_ADDRESS), 160'(0));
        check("rst_inst_data", 160'(INST_MEM_DATA), 160'(0));
        check("rst_d_data", 160'(INDATA_MEM2CAC), 160'(0));
        check("rst_arb_error", 160'(ARB_ERROR), 160'(0));
        RESET = 1'b1;

        // Simultaneous requests after reset: D first, then alternation.
        run_round(1'b1, 1'b1, 1'b0, 6'h07, 6'h21, 32'h0, 2, 3, 1'b0, 0);
        run_round(1'b1, 1'b1, 1'b0, 6'h0A, 6'h22, 32'h0, 1, 0, 1'b0, 0);
        // Lone I read with five busy cycles.
        run_round(1'b1, 1'b0, 1'b0, 6'h05, 6'h00, 32'h0, 5, 0, 1'b0, 0);
        // D write, then read it back.
        run_round(1'b0, 1'b1, 1'b1, 6'h00, 6'h12, 32'hDEADBEEF, 0, 3, 1'b0, 0);
        run_round(1'b0, 1'b1, 1'b0, 6'h00, 6'h12, 32'h0, 0, 1, 1'b0, 0);
        // I wins (D served last) and drops its request mid-grant; D is queued behind it.
        run_round(1'b1, 1'b1, 1'b0, 6'h09, 6'h12, 32'h0, 4, 2, 1'b0, 3);
        // D read with memory stuck busy, then an I read still gets through.
        run_round(1'b0, 1'b1, 1'b0, 6'h00, 6'h33, 32'h0, 0, 0, 1'b1, 0);
        run_round(1'b1, 1'b0, 1'b0, 6'h05, 6'h00, 32'h0, 2, 0, 1'b0, 0);

        // Asynchronous reset in the middle of a D write.
        @(negedge CLK);
        lat_d = 20;
        WRITE_DATA_MEM2CAC  = 1'b1;
        READ_DATA_MEM2CAC   = 1'b0;
        MEM_ADDRESS_MEM2CAC = 6'h12;
        OUTDATA_MEM2CAC     = 32'h12345678;
        repeat (3) @(negedge CLK);
        check("pre_rst_write", 160'(MEM_WRITE), 160'(1));
        #2 RESET = 1'b0;
        #1;
        check("arst_mem_write", 160'(MEM_WRITE), 160'(0));
        check("arst_mem_read", 160'(MEM_READ), 160'(0));
        check("arst_mem_addr", 160'(MEM_ADDRESS), 160'(0));
        check("arst_mem_wdata", 160'(MEM_WRITEDATA), 160'(0));
        check("arst_arb_error", 160'(ARB_ERROR), 160'(0));
        check("arst_inst_data", 160'(INST_MEM_DATA), 160'(0));
        check("arst_d_data", 160'(INDATA_MEM2CAC), 160'(0));
        WRITE_DATA_MEM2CAC = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        txq.delete();
        m_inst   = '0;
        m_data   = '0;
        m_last_d = 1'b0;
        m_err    = 1'b0;

        for (int r = 0; r < 40; r++) begin
            sel = 2'($urandom_range(1, 3));
            run_round(sel[0], sel[1], 1'($urandom_range(0, 1)), 6'($urandom), 6'($urandom), $urandom,
                      $urandom_range(0, 6), $urandom_range(0, 6), 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
